adder_arb: RTL and testbench

ADDER_ARB -- requirements
Module: adder_arb

---
 rtl/adder_arb_pkg.sv | 20 ++
 rtl/adder_arb_add_pipe.sv | 63 ++++++
 rtl/adder_arb.sv | 146 ++++++++++++++
 tb/tb_adder_arb.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared constants and helpers for the round-robin arbitrated adder.
// ADDER_ARB_BACKPRESSURE_EN enables the result FIFO helpers used by adder_arb.
package adder_arb_pkg;

    localparam int ADD_LAT    = 2;
    localparam int FIFO_DEPTH = 3;

    function automatic int id_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

    // Circular increment for the 3-entry result FIFO pointers.
    function automatic logic [1:0] fifo_ptr_inc(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/adder_arb_add_pipe.sv
// Two-stage adder: operands registered on the transfer edge, sum on the next.
// Valid and requester id ride alongside the data as sideband.
module add_pipe
    import adder_arb_pkg::*;
#(
    parameter int W   = 16,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [IDW-1:0] in_id,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic           in_cin,
    output logic           out_valid,
    output logic [IDW-1:0] out_id,
    output logic [W-1:0]   out_s,
    output logic           out_cout
);

    logic [ADD_LAT-1:0] vld_q, vld_d;
    logic [IDW-1:0]     id_q [ADD_LAT];
    logic [IDW-1:0]     id_d [ADD_LAT];
    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic               cin_q, cin_d;
    logic [W:0]         sum_q, sum_d;

    // Operand and sum registers only load when their stage carries a valid op.
    always_comb begin
        vld_d = {vld_q[ADD_LAT-2:0], in_valid};
        id_d[0] = in_id;
        for (int i = 1; i < ADD_LAT; i++) id_d[i] = id_q[i-1];
        a_d   = in_valid ? in_a : a_q;
        b_d   = in_valid ? in_b : b_q;
        cin_d = in_valid ? in_cin : cin_q;
        sum_d = vld_q[0] ? ({1'b0, a_q} + {1'b0, b_q} + (W+1)'(cin_q)) : sum_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < ADD_LAT; i++) id_q[i] <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            sum_q <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
            a_q   <= a_d;
            b_q   <= b_d;
            cin_q <= cin_d;
            sum_q <= sum_d;
        end
    end

    assign out_valid = vld_q[ADD_LAT-1];
    assign out_id    = id_q[ADD_LAT-1];
    assign out_s     = sum_q[W-1:0];
    assign out_cout  = sum_q[W];

endmodule

// File: rtl/adder_arb.sv
// Round-robin arbiter in front of a pipelined adder shared by N requesters.
// Define ADDER_ARB_BACKPRESSURE_EN to add rsp_ready, a 3-entry result FIFO and credits.
module adder_arb
    import adder_arb_pkg::*;
#(
    parameter int W   = 16,
    parameter int N   = 4,
    parameter int IDW = id_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N-1:0]   req_cin,
`ifdef ADDER_ARB_BACKPRESSURE_EN
    input  logic           rsp_ready,
`endif
    output logic           rsp_valid,
    output logic [IDW-1:0] rsp_id,
    output logic [W-1:0]   rsp_s,
    output logic           rsp_cout
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_any;
    logic           allow;
    logic           xfer;
    logic           pipe_valid;
    logic [IDW-1:0] pipe_id;
    logic [W-1:0]   pipe_s;
    logic           pipe_cout;

    // First valid requester at or after the pointer, wrapping at N.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    assign xfer      = rst_n && gnt_any && allow;
    assign req_ready = xfer ? (N'(1) << gnt_idx) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    add_pipe #(.W(W), .IDW(IDW)) u_add_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (xfer),
        .in_id    (gnt_idx),
        .in_a     (req_a[gnt_idx*W +: W]),
        .in_b     (req_b[gnt_idx*W +: W]),
        .in_cin   (req_cin[gnt_idx]),
        .out_valid(pipe_valid),
        .out_id   (pipe_id),
        .out_s    (pipe_s),
        .out_cout (pipe_cout)
    );

`ifdef ADDER_ARB_BACKPRESSURE_EN
    typedef struct packed {
        logic [IDW-1:0] id;
        logic           cout;
        logic [W-1:0]   s;
    } rsp_t;

    rsp_t       mem_q [FIFO_DEPTH];
    rsp_t       mem_d [FIFO_DEPTH];
    logic [1:0] wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d, credit_q, credit_d;
    logic       pop;

    // Credits count everything in the pipe or FIFO, so a full FIFO can never be overrun.
    assign pop   = (cnt_q != 2'd0) && rsp_ready;
    assign allow = (credit_q < 2'(FIFO_DEPTH)) || pop;

    always_comb begin
        mem_d    = mem_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        credit_d = credit_q;
        if (pipe_valid) begin
            mem_d[wr_q] = '{id: pipe_id, cout: pipe_cout, s: pipe_s};
            wr_d        = fifo_ptr_inc(wr_q);
        end
        if (pop) rd_d = fifo_ptr_inc(rd_q);
        case ({pipe_valid, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        case ({xfer, pop})
            2'b10:   credit_d = credit_q + 2'd1;
            2'b01:   credit_d = credit_q - 2'd1;
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            credit_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
        end
    end

    assign rsp_valid = (cnt_q != 2'd0);
    assign rsp_id    = mem_q[rd_q].id;
    assign rsp_s     = mem_q[rd_q].s;
    assign rsp_cout  = mem_q[rd_q].cout;
`else
    assign allow     = 1'b1;
    assign rsp_valid = pipe_valid;
    assign rsp_id    = pipe_id;
    assign rsp_s     = pipe_s;
    assign rsp_cout  = pipe_cout;
`endif

endmodule

// File: tb/tb_adder_arb.sv
// Self-checking bench for adder_arb: directed tables, hand sequences and random traffic
// checked against a cycle-level behavioural model (handles ADDER_ARB_BACKPRESSURE_EN too).
module tb_adder_arb;

   localparam int W   = 16;
   localparam int N   = 4;
   localparam int IDW = 2;
`ifdef ADDER_ARB_BACKPRESSURE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   req_cin;
   logic           rsp_valid;
   logic [IDW-1:0] rsp_id;
   logic [W-1:0]   rsp_s;
   logic           rsp_cout;
`ifdef ADDER_ARB_BACKPRESSURE_EN
   logic           rsp_ready;
`endif

   adder_arb #(.W(W), .N(N), .IDW(IDW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a    (req_a),
      .req_b    (req_b),
      .req_cin  (req_cin),
`ifdef ADDER_ARB_BACKPRESSURE_EN
      .rsp_ready(rsp_ready),
`endif
      .rsp_valid(rsp_valid),
      .rsp_id   (rsp_id),
      .rsp_s    (rsp_s),
      .rsp_cout (rsp_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int id;
      int s;
      int cout;
      int due;
   } result_t;

   typedef struct {
      int         req;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] expS;
      logic         expCout;
   } vector_t;

   result_t pend[$];
`ifdef ADDER_ARB_BACKPRESSURE_EN
   result_t outFifo[$];
`endif
   int ptrModel;
   int cyc;
   int checks;
   int failures;

   logic [N-1:0]   obsReady;
   logic           obsValid;
   logic [IDW-1:0] obsId;
   logic [W-1:0]   obsS;
   logic           obsCout;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [N*W-1:0] place(input int r, input logic [W-1:0] x);
      logic [N*W-1:0] v;
      v = '0;
      v[r*W +: W] = x;
      return v;
   endfunction

   // Model: round-robin from ptrModel, results due LAT cycles after the transfer cycle.
   task automatic modelCycle();
      int g;
      int idx;
      bit allowed;
      bit expValid;
      bit pop;
      result_t e;
      result_t n;
      int unsigned total;
      g = -1;
      pop = 1'b0;
      allowed = 1'b1;
      e = '{0, 0, 0, 0};
`ifdef ADDER_ARB_BACKPRESSURE_EN
      pop = (outFifo.size() > 0) && rsp_ready;
      allowed = ((pend.size() + outFifo.size()) < 3) || pop;
      expValid = outFifo.size() > 0;
      if (expValid) e = outFifo[0];
`else
      expValid = (pend.size() > 0) && (pend[0].due == cyc);
      if (expValid) e = pend[0];
`endif
      if (allowed) begin
         for (int k = 0; k < N; k++) begin
            idx = (ptrModel + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      checkOutput("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(expValid));
      if (expValid) begin
         checkOutput("rsp_id", 32'(rsp_id), e.id);
         checkOutput("rsp_s", 32'(rsp_s), e.s);
         checkOutput("rsp_cout", 32'(rsp_cout), e.cout);
      end
      obsReady = req_ready;
      obsValid = rsp_valid;
      obsId    = rsp_id;
      obsS     = rsp_s;
      obsCout  = rsp_cout;
`ifdef ADDER_ARB_BACKPRESSURE_EN
      if (pop) void'(outFifo.pop_front());
      if (pend.size() > 0 && pend[0].due == cyc) outFifo.push_back(pend.pop_front());
`else
      if (expValid) void'(pend.pop_front());
`endif
      if (g >= 0) begin
         total = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]) + int'(req_cin[g]);
         n.id   = g;
         n.s    = total % (1 << W);
         n.cout = total / (1 << W);
         n.due  = cyc + 2;
         pend.push_back(n);
         ptrModel = (g + 1) % N;
      end
      cyc++;
   endtask

   task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] a,
                                input logic [N*W-1:0] b, input logic [N-1:0] cin);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = v;
      req_a     = a;
      req_b     = b;
      req_cin   = cin;
      @(negedge clk);
      modelCycle();
   endtask

   task automatic applyReset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         rst_n     = 1'b0;
         req_valid = '1;
         @(negedge clk);
         checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
         checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
         checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
         checkOutput("reset_rsp_s", 32'(rsp_s), 32'd0);
         checkOutput("reset_rsp_cout", 32'(rsp_cout), 32'd0);
         pend.delete();
`ifdef ADDER_ARB_BACKPRESSURE_EN
         outFifo.delete();
`endif
         ptrModel = 0;
         cyc++;
      end
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus('0, '0, '0, '0);
   endtask

   vector_t vectors[6];

   initial begin
      int grants;
      checks = 0;
      failures = 0;
      cyc = 0;
      ptrModel = 0;
      rst_n = 1'b0;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      req_cin = '0;
`ifdef ADDER_ARB_BACKPRESSURE_EN
      rsp_ready = 1'b1;
`endif

      vectors[0] = '{2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vectors[1] = '{0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
      vectors[2] = '{1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vectors[3] = '{3, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vectors[4] = '{0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vectors[5] = '{3, 16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0};

      applyReset(3);

      // All requesters valid from reset release: grants rotate 0,1,2,3,...
      for (int i = 0; i < 8; i++) begin
         applyStimulus('1, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
         checkOutput("rr_grant_seq", 32'(obsReady), 32'd1 << (i % N));
      end
      idle(LAT + 1);

      // Single-requester table vectors.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(4'd1 << vectors[i].req, place(vectors[i].req, vectors[i].a),
                       place(vectors[i].req, vectors[i].b), 4'(vectors[i].cin) << vectors[i].req);
         idle(LAT);
         checkOutput("vec_valid", 32'(obsValid), 32'd1);
         checkOutput("vec_id", 32'(obsId), 32'(vectors[i].req));
         checkOutput("vec_s", 32'(obsS), 32'(vectors[i].expS));
         checkOutput("vec_cout", 32'(obsCout), 32'(vectors[i].expCout));
      end

      // Pointer at 2 with requesters 1 and 3 pending: 3 wins, then 1.
      applyReset(1);
      applyStimulus(4'b0010, '0, '0, '0);
      idle(LAT + 1);
      applyStimulus(4'b1010, place(3, 16'h1234) | place(1, 16'h0101),
                    place(3, 16'h4321) | place(1, 16'h0202), 4'b1000);
      checkOutput("ptr_grant_first", 32'(obsReady), 32'b1000);
      applyStimulus(4'b1010, place(3, 16'h1234) | place(1, 16'h0101),
                    place(3, 16'h4321) | place(1, 16'h0202), 4'b1000);
      checkOutput("ptr_grant_second", 32'(obsReady), 32'b0010);
      idle(LAT - 1);
      checkOutput("ptr_rsp_id", 32'(obsId), 32'd3);
      checkOutput("ptr_rsp_s", 32'(obsS), 32'h5556);
      checkOutput("ptr_rsp_cout", 32'(obsCout), 32'd0);
      idle(LAT);

      // Reset pulse with two operations in flight.
      applyStimulus(4'b0011, {$urandom, $urandom}, {$urandom, $urandom}, 4'b0011);
      applyStimulus(4'b0011, {$urandom, $urandom}, {$urandom, $urandom}, 4'b0011);
      applyReset(1);
      for (int i = 0; i < LAT + 2; i++) begin
         applyStimulus('0, '0, '0, '0);
         checkOutput("midreset_no_rsp", 32'(obsValid), 32'd0);
      end
      applyStimulus(4'b1111, '0, '0, '0);
      checkOutput("midreset_ptr0", 32'(obsReady), 32'b0001);
      idle(LAT + 1);

`ifdef ADDER_ARB_BACKPRESSURE_EN
      // Stalled consumer: exactly three grants, then credits run out.
      rsp_ready = 1'b0;
      grants = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus('1, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
         if (obsReady != '0) grants++;
      end
      checkOutput("bp_grant_count", 32'(grants), 32'd3);
      rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++)
         applyStimulus('1, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
      idle(LAT + 1);
`else
      grants = 0;
`endif

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
`ifdef ADDER_ARB_BACKPRESSURE_EN
         rsp_ready = 1'($urandom);
`endif
         applyStimulus(4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
      end
`ifdef ADDER_ARB_BACKPRESSURE_EN
      rsp_ready = 1'b1;
`endif
      idle(LAT + 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
